// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: state encoding and default count width.
package interval_timer_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } timer_state_e;

endpackage

// File: rtl/interval_timer_count.sv
// Down-counter for the interval timer: clear, load, decrement-when-enabled, hold otherwise.
// Never wraps below zero; zero flag is derived from the registered count.
module interval_timer_count #(
    parameter int width = 16
) (
    input  logic             GlobalClock,
    input  logic             clear_n,
    input  logic             clear,
    input  logic             load,
    input  logic [width-1:0] load_value,
    input  logic             enable,
    input  logic             hold,
    output logic [width-1:0] count,
    output logic             zero
);

    logic [width-1:0] count_r;

    // Count register: clear beats load beats decrement.
    always_ff @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && !hold && (count_r != '0)) begin
            count_r <= count_r - width'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == '0);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: IDLE/LOAD/RUN/PAUSE FSM around a down-counter, sticky irq/overrun.
// Optional prescaler enabled by defining INTERVAL_TIMER_PRESCALER_EN.
module interval_timer_ctrl
    import interval_timer_pkg::*;
#(
    parameter int width    = DEFAULT_WIDTH,
    parameter int PRESCALE = 4
) (
    input  logic             GlobalClock,
    input  logic             clear_n,
    input  logic             ClockEnable,
    input  logic             cfg_wr,
    input  logic [width-1:0] cfg_reload,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             irq_ack,
    output logic [width-1:0] CountValue,
    output logic             busy,
    output logic             irq,
    output logic             overrun,
    output logic [1:0]       state
);

    timer_state_e     state_r;
    logic             busy_r;
    logic             irq_r;
    logic             overrun_r;
    logic [width-1:0] reload_r;
    logic             periodic_r;

    logic             tick_s;
    logic             cnt_clear_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_hold_s;
    logic             expiry_s;
    logic [width-1:0] count_s;
    logic             zero_s;

`ifdef INTERVAL_TIMER_PRESCALER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] presc_r;

    // Prescaler: advances on ClockEnable only while running, restarts at every load.
    always_ff @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) begin
            presc_r <= '0;
        end else if (abort) begin
            presc_r <= presc_r;
        end else if (state_r == ST_LOAD) begin
            presc_r <= '0;
        end else if ((state_r == ST_RUN) && !stop && ClockEnable) begin
            presc_r <= (presc_r == PW'(PRESCALE - 1)) ? '0 : presc_r + PW'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    assign tick_s = ClockEnable && (presc_r == PW'(PRESCALE - 1));
`else
    assign tick_s = ClockEnable && (PRESCALE >= 1);
`endif

    // Counter control: what the counter does on the coming edge.
    always_comb begin
        cnt_clear_s = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_hold_s  = (state_r != ST_RUN) || stop;
        expiry_s    = 1'b0;
        if (abort) begin
            cnt_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_LOAD: cnt_load_s = 1'b1;
                ST_RUN: begin
                    if (!stop && tick_s) begin
                        if (zero_s) begin
                            expiry_s   = 1'b1;
                            cnt_load_s = periodic_r;
                        end else begin
                            cnt_dec_s = 1'b1;
                        end
                    end else begin
                        cnt_dec_s = 1'b0;
                    end
                end
                default: cnt_dec_s = 1'b0;
            endcase
        end
    end

    interval_timer_count #(.width(width)) u_count (
        .GlobalClock(GlobalClock),
        .clear_n    (clear_n),
        .clear      (cnt_clear_s),
        .load       (cnt_load_s),
        .load_value (reload_r),
        .enable     (cnt_dec_s),
        .hold       (cnt_hold_s),
        .count      (count_s),
        .zero       (zero_s)
    );

    // Main FSM with registered busy flag; abort overrides every state.
    always_ff @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_RUN;
                    busy_r  <= 1'b1;
                end
                ST_RUN: begin
                    if (stop) begin
                        state_r <= ST_PAUSE;
                        busy_r  <= 1'b1;
                    end else if (expiry_s && !periodic_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    state_r <= start ? ST_RUN : ST_PAUSE;
                    busy_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Configuration registers; a write is only seen by the next load or reload.
    always_ff @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) begin
            reload_r   <= '0;
            periodic_r <= 1'b0;
        end else if (cfg_wr) begin
            reload_r   <= cfg_reload;
            periodic_r <= cfg_periodic;
        end else begin
            reload_r   <= reload_r;
            periodic_r <= periodic_r;
        end
    end

    // Sticky status flags: an expiry set beats a coincident acknowledge.
    always_ff @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) begin
            irq_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else if (expiry_s) begin
            irq_r     <= 1'b1;
            overrun_r <= overrun_r | irq_r;
        end else if (irq_ack) begin
            irq_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            irq_r     <= irq_r;
            overrun_r <= overrun_r;
        end
    end

    assign CountValue = count_s;
    assign busy       = busy_r;
    assign irq        = irq_r;
    assign overrun    = overrun_r;
    assign state      = state_r;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl (default build, no prescaler):
// directed literal scenarios followed by randomized traffic against a behavioural model.
module tb_interval_timer_ctrl;

    localparam int W = 16;

    logic         GlobalClock = 1'b0;
    logic         clear_n     = 1'b0;
    logic         ClockEnable = 1'b0;
    logic         cfg_wr      = 1'b0;
    logic [W-1:0] cfg_reload  = '0;
    logic         cfg_periodic = 1'b0;
    logic         start       = 1'b0;
    logic         stop        = 1'b0;
    logic         abort       = 1'b0;
    logic         irq_ack     = 1'b0;
    logic [W-1:0] CountValue;
    logic         busy;
    logic         irq;
    logic         overrun;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    always #5 GlobalClock = ~GlobalClock;

    interval_timer_ctrl #(.width(W), .PRESCALE(4)) dut (
        .GlobalClock (GlobalClock),
        .clear_n     (clear_n),
        .ClockEnable (ClockEnable),
        .cfg_wr      (cfg_wr),
        .cfg_reload  (cfg_reload),
        .cfg_periodic(cfg_periodic),
        .start       (start),
        .stop        (stop),
        .abort       (abort),
        .irq_ack     (irq_ack),
        .CountValue  (CountValue),
        .busy        (busy),
        .irq         (irq),
        .overrun     (overrun),
        .state       (state)
    );

    typedef struct packed {
        logic [1:0]   st;
        logic [W-1:0] cnt;
        logic [W-1:0] reload;
        logic         periodic;
        logic         irq;
        logic         ovr;
    } mdl_t;

    mdl_t m;

    // Timer behaviour from its rules: 0 idle, 1 load, 2 run, 3 pause.
    function automatic mdl_t next_model(mdl_t c);
        mdl_t n;
        bit   expire;
        n = c;
        expire = 1'b0;
        if (cfg_wr) begin
            n.reload   = cfg_reload;
            n.periodic = cfg_periodic;
        end
        if (abort) begin
            n.st  = 2'd0;
            n.cnt = '0;
        end else if (c.st == 2'd0) begin
            if (start) n.st = 2'd1;
        end else if (c.st == 2'd1) begin
            n.cnt = c.reload;
            n.st  = 2'd2;
        end else if (c.st == 2'd2) begin
            if (stop) n.st = 2'd3;
            else if (ClockEnable) begin
                if (c.cnt > 0) n.cnt = c.cnt - 1;
                else begin
                    expire = 1'b1;
                    if (c.periodic) n.cnt = c.reload;
                    else n.st = 2'd0;
                end
            end
        end else begin
            if (start) n.st = 2'd2;
        end
        if (irq_ack) begin
            n.irq = 1'b0;
            n.ovr = 1'b0;
        end
        if (expire) begin
            if (c.irq) n.ovr = 1'b1;
            n.irq = 1'b1;
        end
        return n;
    endfunction

    always @(posedge GlobalClock or negedge clear_n) begin
        if (!clear_n) m <= '0;
        else m <= next_model(m);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge GlobalClock) begin
        total = total + 1;
        if ({state, CountValue, busy, irq, overrun} !== {m.st, m.cnt, (m.st != 2'd0), m.irq, m.ovr}) begin
            bad = bad + 1;
            $display("FAIL model_cmp t=%0t got st=%0d cnt=%0d busy=%b irq=%b ovr=%b expected st=%0d cnt=%0d busy=%b irq=%b ovr=%b",
                     $time, state, CountValue, busy, irq, overrun, m.st, m.cnt, (m.st != 2'd0), m.irq, m.ovr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge GlobalClock);
        #1;
    endtask

    task automatic write_cfg(input int rl, input bit per);
        cfg_wr = 1'b1; cfg_reload = W'(rl); cfg_periodic = per;
        cyc();
        cfg_wr = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        chk("reset_state", state, 0);
        chk("reset_count", CountValue, 0);
        chk("reset_busy", busy, 0);
        chk("reset_irq", irq, 0);
        chk("reset_ovr", overrun, 0);
        clear_n = 1'b1;
        ClockEnable = 1'b1;

        // One-shot reload 3
        write_cfg(3, 1'b0);
        start_pulse();
        chk("os_load_state", state, 1);
        cyc(); chk("os_run_state", state, 2); chk("os_run_cnt3", CountValue, 3);
        cyc(); chk("os_cnt2", CountValue, 2);
        cyc(); chk("os_cnt1", CountValue, 1);
        cyc(); chk("os_cnt0", CountValue, 0); chk("os_irq_before", irq, 0);
        cyc(); chk("os_exp_state", state, 0); chk("os_exp_irq", irq, 1);
        chk("os_exp_cnt", CountValue, 0); chk("os_exp_busy", busy, 0);

        // Stop/pause/resume, then abort with irq pending
        write_cfg(10, 1'b0);
        start_pulse();
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        chk("pause_pre_cnt", CountValue, 6);
        stop = 1'b1;
        cyc();
        chk("pause_state", state, 3); chk("pause_cnt", CountValue, 6);
        for (int i = 0; i < 5; i++) begin
            stop = (i % 2 == 0);
            cyc();
            chk("pause_hold_cnt", CountValue, 6); chk("pause_hold_state", state, 3);
        end
        stop = 1'b0;
        start_pulse();
        chk("resume_state", state, 2); chk("resume_cnt", CountValue, 6);
        cyc(); chk("resume_cnt5", CountValue, 5);
        cyc(); chk("resume_cnt4", CountValue, 4);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_state", state, 0); chk("abort_cnt", CountValue, 0); chk("abort_irq", irq, 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("ack_irq", irq, 0);

        // Periodic reload 2, overrun
        write_cfg(2, 1'b1);
        start_pulse();
        for (int i = 0; i < 4; i++) cyc();
        chk("per_exp1_irq", irq, 1); chk("per_exp1_ovr", overrun, 0);
        chk("per_exp1_cnt", CountValue, 2); chk("per_exp1_state", state, 2);
        for (int i = 0; i < 3; i++) cyc();
        chk("per_exp2_ovr", overrun, 1); chk("per_exp2_cnt", CountValue, 2);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("per_ack_irq", irq, 0); chk("per_ack_ovr", overrun, 0); chk("per_ack_cnt", CountValue, 1);

        // Expiry with coincident ack and cfg_wr
        cyc(); cyc();
        chk("co_irq_pre", irq, 1);
        cyc(); cyc();
        chk("co_cnt0", CountValue, 0);
        irq_ack = 1'b1; cfg_wr = 1'b1; cfg_reload = W'(7); cfg_periodic = 1'b1;
        cyc();
        irq_ack = 1'b0; cfg_wr = 1'b0;
        chk("co_irq", irq, 1); chk("co_ovr", overrun, 1); chk("co_old_reload", CountValue, 2);
        cyc(); cyc(); cyc();
        chk("co_new_reload", CountValue, 7);
        abort = 1'b1; irq_ack = 1'b1;
        cyc();
        abort = 1'b0; irq_ack = 1'b0;

        // Asynchronous reset mid-run
        write_cfg(10, 1'b0);
        start_pulse();
        for (int i = 0; i < 6; i++) cyc();
        chk("rst_pre_cnt", CountValue, 5);
        clear_n = 1'b0;
        #1;
        chk("rst_state", state, 0); chk("rst_cnt", CountValue, 0);
        chk("rst_busy", busy, 0); chk("rst_irq", irq, 0); chk("rst_ovr", overrun, 0);
        cyc();
        clear_n = 1'b1;
        start_pulse();
        cyc();
        chk("zero_reload_cnt", CountValue, 0); chk("zero_reload_state", state, 2);
        cyc();
        chk("zero_reload_exp_state", state, 0); chk("zero_reload_exp_irq", irq, 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ClockEnable  = ($urandom_range(0, 9) < 7);
            cfg_wr       = ($urandom_range(0, 19) == 0);
            cfg_reload   = W'($urandom_range(0, 12));
            cfg_periodic = $urandom_range(0, 1);
            start        = (m.st != 2'd2) && ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 19) == 0);
            abort        = ($urandom_range(0, 49) == 0);
            irq_ack      = ($urandom_range(0, 9) == 0);
            clear_n      = ($urandom_range(0, 299) != 0);
            cyc();
        end
        clear_n = 1'b1; cfg_wr = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; irq_ack = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
